// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store size codes, drain FSM states
// and the layout of one buffered entry.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } entry_t;

endpackage

// File: rtl/store_buffer_st_align.sv
// Combinational lane steering: turns a right-justified store into
// byte strobes plus lane-aligned data, and flags misaligned/illegal sizes.
module st_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  // Strobe, data lane and alignment decode for one store
  always_comb begin
    o_strb     = 4'b0000;
    o_wdata    = 32'd0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_strb  = 4'b0001 << i_addr_lo;
        o_wdata = {24'd0, i_data[7:0]} << {i_addr_lo, 3'b000};
      end
      SZ_HALF: begin
        o_misalign = i_addr_lo[0];
        if (i_addr_lo[1]) begin
          o_strb  = 4'b1100;
          o_wdata = {i_data[15:0], 16'd0};
        end else begin
          o_strb  = 4'b0011;
          o_wdata = {16'd0, i_data[15:0]};
        end
      end
      SZ_WORD: begin
        o_misalign = (i_addr_lo != 2'b00);
        o_strb     = 4'b1111;
        o_wdata    = i_data;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Retired-store buffer: queues aligned stores and drains them to data
// memory one request at a time, flagging loads that overlap a pending store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_write,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_data,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_misalign,
  output logic        o_ovf,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_strb,
  input  logic        i_mem_ack,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_addr,
  output logic        o_ld_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             buf_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_next_s;
  logic [CNT_W-1:0]   count_r;
  state_e             state_r;
  state_e             state_next_s;
  entry_t             in_entry_s;
  entry_t             next_head_s;
  logic               mis_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               load_head_s;
  logic               hit_s;
  logic               misalign_r;
  logic               ovf_r;
  logic               mem_req_r;
  logic [31:0]        mem_addr_r;
  logic [31:0]        mem_wdata_r;
  logic [3:0]         mem_strb_r;
  logic               ld_lo_unused_s;

  st_align u_align (
    .i_size     (i_size),
    .i_addr_lo  (i_wr_addr[1:0]),
    .i_data     (i_data),
    .o_strb     (in_entry_s.strb),
    .o_wdata    (in_entry_s.wdata),
    .o_misalign (mis_s)
  );

  assign in_entry_s.addr = i_wr_addr[31:2];
  assign full_s          = (count_r == CNT_W'(DEPTH));
  assign push_s          = i_write & ~full_s & ~mis_s;
  assign rd_next_s       = rd_ptr_r + 1'b1;
  assign ld_lo_unused_s  = ^i_ld_addr[1:0];

  // Drain FSM next state; also picks the entry to present after this edge
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    load_head_s  = 1'b0;
    next_head_s  = buf_r[rd_ptr_r];
    case (state_r)
      ST_IDLE: begin
        if (count_r != '0) begin
          state_next_s = ST_REQ;
          load_head_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          pop_s = 1'b1;
          // A store arriving while the last entry drains is forwarded straight to the port
          if (count_r > CNT_W'(1)) begin
            next_head_s = buf_r[rd_next_s];
            load_head_s = 1'b1;
          end else if (push_s) begin
            next_head_s = in_entry_s;
            load_head_s = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_REQ;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control state, pointers, flags and the registered memory port
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      misalign_r  <= 1'b0;
      ovf_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_strb_r  <= 4'b0000;
    end else begin
      state_r    <= state_next_s;
      misalign_r <= i_write & mis_s;
      if (i_write && full_s) begin
        ovf_r <= 1'b1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      mem_req_r <= (state_next_s == ST_REQ);
      if (load_head_s) begin
        mem_addr_r  <= {next_head_s.addr, 2'b00};
        mem_wdata_r <= next_head_s.wdata;
        mem_strb_r  <= next_head_s.strb;
      end
    end
  end

  // Entry storage; contents are only meaningful inside the valid window
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      buf_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // Load overlap: any entry between rd_ptr and rd_ptr+count with the same word address
  always_comb begin
    logic [PTR_W-1:0] off_v;
    hit_s = 1'b0;
    off_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v = PTR_W'(i) - rd_ptr_r;
      if (({1'b0, off_v} < count_r) && (buf_r[i].addr == i_ld_addr[31:2])) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign o_ld_hit    = i_ld_valid & hit_s;
  assign o_full      = full_s;
  assign o_empty     = (count_r == '0) && (state_r == ST_IDLE);
  assign o_misalign  = misalign_r;
  assign o_ovf       = ovf_r;
  assign o_mem_req   = mem_req_r;
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wdata = mem_wdata_r;
  assign o_mem_strb  = mem_strb_r;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: hand-computed expectations for alignment,
// overflow, drain ordering, load hazard detection and mid-request reset.
module tb_store_buffer;

  logic        i_clk;
  logic        i_rstn;
  logic        i_write;
  logic [1:0]  i_size;
  logic [31:0] i_wr_addr;
  logic [31:0] i_data;
  logic        o_full;
  logic        o_empty;
  logic        o_misalign;
  logic        o_ovf;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_strb;
  logic        i_mem_ack;
  logic        i_ld_valid;
  logic [31:0] i_ld_addr;
  logic        o_ld_hit;

  int checks_r;
  int errors_r;
  int req_seen;

  store_buffer #(.DEPTH(4)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_write     (i_write),
    .i_size      (i_size),
    .i_wr_addr   (i_wr_addr),
    .i_data      (i_data),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_misalign  (o_misalign),
    .o_ovf       (o_ovf),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_strb  (o_mem_strb),
    .i_mem_ack   (i_mem_ack),
    .i_ld_valid  (i_ld_valid),
    .i_ld_addr   (i_ld_addr),
    .o_ld_hit    (o_ld_hit)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
    i_write   = 1'b1;
    i_size    = sz;
    i_wr_addr = addr;
    i_data    = data;
    tick();
    i_write   = 1'b0;
  endtask

  initial begin
    checks_r   = 0;
    errors_r   = 0;
    i_rstn     = 1'b0;
    i_write    = 1'b0;
    i_size     = 2'd0;
    i_wr_addr  = 32'd0;
    i_data     = 32'd0;
    i_mem_ack  = 1'b1;
    i_ld_valid = 1'b0;
    i_ld_addr  = 32'd0;
    repeat (2) tick();
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_mis", o_misalign, 0);
    chk("rst_addr", o_mem_addr, 0);
    i_rstn = 1'b1;
    tick();

    // byte 0xAB at 0x103
    store(2'd0, 32'h0000_0103, 32'h0000_00AB);
    chk("b_notempty", o_empty, 0);
    tick();
    chk("b_req", o_mem_req, 1);
    chk("b_addr", o_mem_addr, 32'h0000_0100);
    chk("b_strb", o_mem_strb, 4'b1000);
    chk("b_wdata", o_mem_wdata, 32'hAB00_0000);
    tick();
    chk("b_req_done", o_mem_req, 0);
    chk("b_empty", o_empty, 1);

    // half at 0x202, then misaligned word at 0x201
    store(2'd1, 32'h0000_0202, 32'h0000_1234);
    tick();
    chk("h_addr", o_mem_addr, 32'h0000_0200);
    chk("h_strb", o_mem_strb, 4'b1100);
    chk("h_wdata", o_mem_wdata, 32'h1234_0000);
    tick();
    chk("h_empty", o_empty, 1);
    store(2'd2, 32'h0000_0201, 32'hDEAD_BEEF);
    chk("mis_pulse", o_misalign, 1);
    chk("mis_empty", o_empty, 1);
    tick();
    chk("mis_clear", o_misalign, 0);
    chk("mis_noreq", o_mem_req, 0);
    store(2'd3, 32'h0000_0200, 32'h0);
    chk("ill_pulse", o_misalign, 1);
    tick();
    chk("ill_noreq", o_mem_req, 0);

    // five words with ack low: fourth fills, fifth dropped
    i_mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      store(2'd2, 32'h0000_0400 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1));
      if (k == 3) begin
        chk("f_full4", o_full, 1);
        chk("f_ovf4", o_ovf, 0);
      end
    end
    chk("f_ovf", o_ovf, 1);
    chk("f_full5", o_full, 1);
    i_mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("d_req", o_mem_req, 1);
      chk("d_addr", o_mem_addr, 32'h0000_0400 + 32'(4 * k));
      chk("d_wdata", o_mem_wdata, 32'h1111_1111 * 32'(k + 1));
      tick();
    end
    chk("d_idle", o_mem_req, 0);
    chk("d_empty", o_empty, 1);
    chk("d_ovf_sticky", o_ovf, 1);

    // load hazard against a pending word at 0x300
    i_mem_ack = 1'b0;
    store(2'd2, 32'h0000_0300, 32'hCAFE_F00D);
    i_ld_valid = 1'b1;
    i_ld_addr  = 32'h0000_0302;
    #1;
    chk("ld_hit", o_ld_hit, 1);
    i_ld_addr = 32'h0000_0304;
    #1;
    chk("ld_miss", o_ld_hit, 0);
    i_ld_valid = 1'b0;
    i_ld_addr  = 32'h0000_0300;
    #1;
    chk("ld_novalid", o_ld_hit, 0);
    tick();
    i_ld_valid = 1'b1;
    #1;
    chk("ld_inflight", o_ld_hit, 1);
    i_ld_valid = 1'b0;
    i_mem_ack  = 1'b1;
    tick();
    chk("ld_drained", o_empty, 1);

    // simultaneous enqueue and pop at count 2
    i_mem_ack = 1'b0;
    store(2'd2, 32'h0000_0500, 32'h0000_000A);
    store(2'd2, 32'h0000_0504, 32'h0000_000B);
    chk("sp_head", o_mem_addr, 32'h0000_0500);
    chk("sp_cnt2", dut.count_r, 2);
    i_mem_ack = 1'b1;
    store(2'd2, 32'h0000_0508, 32'h0000_000C);
    chk("sp_cnt_same", dut.count_r, 2);
    chk("sp_addr_b", o_mem_addr, 32'h0000_0504);
    chk("sp_data_b", o_mem_wdata, 32'h0000_000B);
    tick();
    chk("sp_addr_c", o_mem_addr, 32'h0000_0508);
    chk("sp_data_c", o_mem_wdata, 32'h0000_000C);
    tick();
    chk("sp_idle", o_mem_req, 0);
    chk("sp_empty", o_empty, 1);

    // reset in the middle of a request
    i_mem_ack = 1'b0;
    store(2'd2, 32'h0000_0600, 32'h0000_0066);
    tick();
    chk("r_req_before", o_mem_req, 1);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("r_req_low", o_mem_req, 0);
    chk("r_empty", o_empty, 1);
    chk("r_ovf", o_ovf, 0);
    chk("r_full", o_full, 0);
    tick();
    i_rstn    = 1'b1;
    i_mem_ack = 1'b1;
    req_seen  = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_mem_req) req_seen++;
    end
    chk("r_no_retry", req_seen, 0);
    chk("r_empty_after", o_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
